xs_transmitter: RTL

//  Asynchronous serial transmitter, the send side of the xsr receiver. Accepts a parallel

---
 rtl/xs_pkg.sv | 9 +
 rtl/xs_transmitter_if.sv | 36 +++
 rtl/xs_bit_timer.sv | 37 +++
 rtl/xs_transmitter.sv | 107 ++++++++++
 4 files changed

// File: rtl/xs_pkg.sv
// xs_pkg: constants shared by the xs serial transmitter and the xsr receiver.
//   DW        data / shift-register / baud-counter width
//   BW        bit-count width; frames carry 0..2**BW-1 bits
//   LINE_IDLE level of the serial line when nothing is being sent
package xs_pkg;
  localparam int DW = 64;
  localparam int BW = 6;
  localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/xs_transmitter_if.sv
// xs_transmitter_if: host-side bundle of the xs transmitter.
//   dat_i   frame data, bit 0 sent first
//   bits_i  frame length in bits (start/stop bits are part of dat_i)
//   we_i    write strobe (valid)
//   baud_i  bit period minus one, in clocks
//   ready_o holding register empty
//   txd_o   registered serial line
//   txc_o   pulse in the first cycle of each bit on txd_o
//   idle_o  nothing on the wire and nothing queued
// Handshake: we_i acts as valid and ready_o as ready; a frame transfers on
// exactly the rising clock edge where we_i & ready_o are both high. ready_o
// depends on registered state only, never on we_i. we_i while ready_o is low
// is ignored and does not overwrite the queued frame.
interface xs_transmitter_if #(
  parameter int DW = xs_pkg::DW,
  parameter int BW = xs_pkg::BW
);
  logic [DW-1:0] dat_i;
  logic [BW-1:0] bits_i;
  logic          we_i;
  logic [DW-1:0] baud_i;
  logic          ready_o;
  logic          txd_o;
  logic          txc_o;
  logic          idle_o;

  modport master (
    output dat_i, bits_i, we_i, baud_i,
    input  ready_o, txd_o, txc_o, idle_o
  );

  modport slave (
    input  dat_i, bits_i, we_i, baud_i,
    output ready_o, txd_o, txc_o, idle_o
  );
endinterface

// File: rtl/xs_bit_timer.sv
// xs_bit_timer: bit-period down-counter for the xs transmitter.
//   clk_i, reset_i  clock and synchronous active-high reset
//   load_i          reload the counter with baud_i (start of a new bit)
//   dec_i           count down by one
//   baud_i          bit period minus one, in clocks
//   tick_o          counter is zero: the current bit ends on this clock
module xs_bit_timer #(
  parameter int DW = xs_pkg::DW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [DW-1:0] baud_i,
  output logic          tick_o
);
  logic [DW-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (load_i) begin
      ctr_d = baud_i;
    end else if (dec_i) begin
      ctr_d = ctr_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign tick_o = (ctr_q == '0);
endmodule

// File: rtl/xs_transmitter.sv
// xs_transmitter: asynchronous serial transmitter, LSB first, line idles high.
// Each bit is held baud_i+1 clocks. A one-entry holding register lets the host
// queue the next frame while the current one is on the wire.
//   clk_i    system clock, all state on posedge
//   reset_i  synchronous active-high reset; aborts a frame at once
//   bus      xs_transmitter_if slave: dat_i, bits_i, we_i, baud_i in;
//            ready_o, txd_o, txc_o, idle_o out
module xs_transmitter
  import xs_pkg::*;
#(
  parameter int DW = xs_pkg::DW,
  parameter int BW = xs_pkg::BW
) (
  input  logic clk_i,
  input  logic reset_i,
  xs_transmitter_if.slave bus
);
  logic [DW-1:0] sr_q, sr_d;
  logic [BW-1:0] bits_left_q, bits_left_d;
  logic [DW-1:0] hold_dat_q, hold_dat_d;
  logic [BW-1:0] hold_bits_q, hold_bits_d;
  logic          hold_full_q, hold_full_d;
  logic          txc_q, txc_d;

  logic          tick;
  logic          timer_load;
  logic          timer_dec;
  logic          do_load;
  logic [DW-1:0] low_mask;

  xs_bit_timer #(.DW(DW)) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (timer_load),
    .dec_i   (timer_dec),
    .baud_i  (bus.baud_i),
    .tick_o  (tick)
  );

  // A queued frame loads when the shifter is empty, or in the last clock of
  // the final bit so the next frame follows with no idle gap.
  assign do_load = hold_full_q &
                   ((bits_left_q == '0) | ((bits_left_q == BW'(1)) & tick));

  // Bits above the frame length are forced to the idle level so the line
  // returns high once the frame has shifted out; a zero-length frame becomes
  // all idle and never disturbs the line.
  assign low_mask = (DW'(1) << hold_bits_q) - DW'(1);

  always_comb begin
    sr_d        = sr_q;
    bits_left_d = bits_left_q;
    hold_dat_d  = hold_dat_q;
    hold_bits_d = hold_bits_q;
    hold_full_d = hold_full_q;
    txc_d       = 1'b0;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;

    if (do_load) begin
      sr_d        = hold_dat_q | ~low_mask;
      bits_left_d = hold_bits_q;
      hold_full_d = 1'b0;
      timer_load  = 1'b1;
      txc_d       = (hold_bits_q != '0);
    end else if (bits_left_q != '0) begin
      if (!tick) begin
        timer_dec = 1'b1;
      end else begin
        sr_d        = {LINE_IDLE, sr_q[DW-1:1]};
        bits_left_d = bits_left_q - BW'(1);
        timer_load  = 1'b1;
        txc_d       = (bits_left_q > BW'(1));
      end
    end

    // Never coincides with a load: loading needs the holding register full.
    if (bus.we_i && !hold_full_q) begin
      hold_dat_d  = bus.dat_i;
      hold_bits_d = bus.bits_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q        <= {DW{LINE_IDLE}};
      bits_left_q <= '0;
      hold_dat_q  <= '0;
      hold_bits_q <= '0;
      hold_full_q <= 1'b0;
      txc_q       <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bits_left_q <= bits_left_d;
      hold_dat_q  <= hold_dat_d;
      hold_bits_q <= hold_bits_d;
      hold_full_q <= hold_full_d;
      txc_q       <= txc_d;
    end
  end

  assign bus.ready_o = ~hold_full_q;
  assign bus.txd_o   = sr_q[0];
  assign bus.txc_o   = txc_q;
  assign bus.idle_o  = (bits_left_q == '0) & ~hold_full_q;
endmodule
